dds_frame_loader: RTL
=====================

// Module: dds_frame_loader
// PURPOSE
//  Upstream stage of the DDS SPI serializer. Receives bytes from the Rabbit
//  over an 8-bit parallel strobe bus and assembles them into complete DDS
//  register frames: an instruction byte plus a payload, left-justified. Each
//  finished frame goes to the serializer over a valid/ready handshake. Sweep
//  limits, step and rate registers are loaded at run time from user input.
// PARAMETERS
//  TIMEOUT    20000  max clocks allowed between bytes inside one frame
//  SYNC_STG   2      strobe synchronizer flops (minimum 2)
// PORTS
//  tenMHz_ext    in   1   system clock, 10 MHz
//  reset_n       in   1   asynchronous reset, active low
//  rab_data      in   8   Rabbit byte; stable while rab_strobe is high
//  rab_strobe    in   1   Rabbit byte strobe, asynchronous, active high
//  rab_busy      out  1   high = loader cannot accept a byte
//  frame_data    out  72  instruction byte in [71:64], payload below, zero-filled
//  frame_bits    out  7   frame length in bits: 40 or 72
//  frame_valid   out  1   frame_data/frame_bits valid
//  frame_ready   in   1   serializer accepts frame when valid&&ready
//  hdr_err       out  1   sticky: illegal instruction byte received
//  ovr_err       out  1   sticky: byte arrived while rab_busy
//  tmo_err       out  1   sticky: frame aborted by inter-byte timeout
//  err_clr       in   1   synchronous clear of all sticky errors
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0, FSM=IDLE, buffers empty, timer 0.
//  Strobe path: SYNC_STG flops, then a rising-edge detect. The byte is latched
//   from rab_data on the detect cycle. Latency is SYNC_STG+1 clocks after the
//   pin edge. The Rabbit holds rab_strobe high >= 4 clocks and low >= 4 clocks.
//  Header decode (first byte of a frame) gives payload length:
//   0x00,0x01,0x02,0x03,0x0D -> 4 bytes (frame_bits=40)
//   0x0B,0x0C               -> 8 bytes (frame_bits=72)
//   other -> hdr_err<=1, byte discarded, FSM stays IDLE.
//  FSM:
//   IDLE: on legal header, load it into asm[71:64], clear asm[63:0], set
//    cnt=len, go to PAYLOAD.
//   PAYLOAD: each byte is placed MSB-first, byte k (0-based) at
//    asm[63-8k -: 8]; cnt--. The last byte goes to COMMIT.
//   COMMIT (1 clk): if the hold register is empty, copy asm plus length into
//    hold, set frame_valid=1, go to IDLE. Otherwise stay in COMMIT.
//  Hold register: frame_valid clears the cycle after valid&&ready. A commit can
//   refill hold on that same cycle, giving back-to-back frames with no bubble.
//  rab_busy = (FSM==COMMIT). Registered, so it asserts the cycle after the
//   last payload byte is latched.
//  Byte edge while rab_busy: byte dropped, ovr_err<=1, FSM unchanged.
//  Timeout: timer clears on every accepted byte and counts in PAYLOAD only.
//   When timer reaches TIMEOUT: asm discarded, tmo_err<=1, FSM to IDLE. A byte
//   edge on that same cycle is treated as a new header.
//  err_clr, when asserted together with a new error event: the set wins.
//  frame_data/frame_bits hold their value while frame_valid=1 and ready=0.
//  Reset mid-frame aborts everything. No partial frame ever reaches frame_valid.
// TESTING
//  1 Bytes 0B 07 AE 14 7A 03 D7 0A 3D, ready=1 -> one valid pulse;
//    frame_data=72'h0B07AE147A03D70A3D, frame_bits=72.
//  2 Bytes 0D 00 01 00 01 -> frame_data=72'h0D00010001_00000000,
//    frame_bits=40.
//  3 Header 05, then 00 00000000 -> hdr_err=1 after 05. The 00 frame is
//    accepted normally, bits=40.
//  4 ready=0, send two 0B frames, then one extra byte -> frame 1 held,
//    rab_busy=1, extra byte dropped, ovr_err=1. Raise ready -> frames 1 and 2
//    emitted in order, rab_busy falls.
//  5 Header 0C + 3 bytes, wait TIMEOUT clocks -> tmo_err=1, no frame. Next
//    0C frame assembles correctly.
//  6 reset_n low during PAYLOAD of a 0B frame -> outputs 0 at once. A fresh
//    frame after release is correct. err_clr clears all sticky flags.

Source files
------------

// File: rtl/dds_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dds_frame_loader
//  Description : Upstream stage of the DDS SPI serializer. Collects bytes
//                from the Rabbit's 8-bit strobe bus and assembles them into
//                DDS register frames: instruction byte in [71:64], payload
//                left-justified below it, zero-filled. Finished frames are
//                offered to the serializer through a one-deep hold register
//                with a valid/ready handshake.
//  Ports       : tenMHz_ext  - 10 MHz system clock
//                reset_n     - asynchronous reset, active low
//                rab_data    - Rabbit byte (stable while rab_strobe high)
//                rab_strobe  - asynchronous byte strobe, active high
//                rab_busy    - loader cannot accept a byte (frame waiting)
//                frame_data  - assembled frame, 72 bits
//                frame_bits  - frame length in bits (40 or 72)
//                frame_valid - frame_data/frame_bits valid
//                frame_ready - serializer accepts on valid && ready
//                hdr_err     - sticky: illegal instruction byte seen
//                ovr_err     - sticky: byte arrived while busy
//                tmo_err     - sticky: frame aborted by inter-byte timeout
//                err_clr     - synchronous clear of the sticky errors
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_frame_loader #(
    parameter int TIMEOUT  = 20000,
    parameter int SYNC_STG = 2
) (
    input  logic        tenMHz_ext,
    input  logic        reset_n,
    input  logic [7:0]  rab_data,
    input  logic        rab_strobe,
    output logic        rab_busy,
    output logic [71:0] frame_data,
    output logic [6:0]  frame_bits,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        hdr_err,
    output logic        ovr_err,
    output logic        tmo_err,
    input  logic        err_clr
);

    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_COMMIT  = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]          state_q,     state_d;
    logic [SYNC_STG-1:0] sync_q,      sync_d;
    logic                sprev_q,     sprev_d;
    logic [71:0]         asm_q,       asm_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                long_q,      long_d;
    logic [c_TMR_W-1:0]  timer_q,     timer_d;
    logic [71:0]         hold_q,      hold_d;
    logic [6:0]          hold_bits_q, hold_bits_d;
    logic                valid_q,     valid_d;
    logic                busy_q,      busy_d;
    logic                hdr_err_q,   hdr_err_d;
    logic                ovr_err_q,   ovr_err_d;
    logic                tmo_err_q,   tmo_err_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic       w_byte_evt;   // rising edge of the synchronized strobe
    logic       w_byte_acc;   // byte edge that the loader takes
    logic       w_tmo;        // inter-byte timer expired this cycle
    logic       w_hdr_ctx;    // an accepted byte this cycle is a header
    logic       w_hdr_ok;
    logic       w_hdr_long;
    logic       w_hold_free;
    logic       w_commit;
    logic [3:0] w_k;          // 0-based payload byte index

    assign w_byte_evt  = sync_q[SYNC_STG-1] & ~sprev_q;
    assign w_byte_acc  = w_byte_evt & ~busy_q;
    assign w_tmo       = (state_q == c_ST_PAYLOAD) && (timer_q == c_TMR_W'(TIMEOUT));
    // A byte landing on the timeout cycle starts a new frame.
    assign w_hdr_ctx   = (state_q == c_ST_IDLE) || w_tmo;
    // The hold register is free if empty or being drained this very cycle,
    // which lets a commit refill it with no bubble.
    assign w_hold_free = ~valid_q | frame_ready;
    assign w_commit    = (state_q == c_ST_COMMIT) && w_hold_free;
    assign w_k         = (long_q ? 4'd8 : 4'd4) - cnt_q;

    always_comb begin
        w_hdr_ok   = 1'b0;
        w_hdr_long = 1'b0;
        case (rab_data)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h0D: w_hdr_ok = 1'b1;
            8'h0B, 8'h0C: begin
                w_hdr_ok   = 1'b1;
                w_hdr_long = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge tenMHz_ext or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_byte_acc && w_hdr_ok) begin
                    state_d = c_ST_PAYLOAD;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_tmo) begin
                    state_d = (w_byte_acc && w_hdr_ok) ? c_ST_PAYLOAD : c_ST_IDLE;
                end else if (w_byte_acc && (cnt_q == 4'd1)) begin
                    state_d = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                if (w_hold_free) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        sync_d      = {sync_q[SYNC_STG-2:0], rab_strobe};
        sprev_d     = sync_q[SYNC_STG-1];
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        long_d      = long_q;
        timer_d     = '0;
        hold_d      = hold_q;
        hold_bits_d = hold_bits_q;
        valid_d     = valid_q;
        busy_d      = (state_d == c_ST_COMMIT);
        hdr_err_d   = hdr_err_q & ~err_clr;
        ovr_err_d   = ovr_err_q & ~err_clr;
        tmo_err_d   = tmo_err_q & ~err_clr;

        // Timer runs only while waiting for a payload byte.
        if ((state_q == c_ST_PAYLOAD) && !w_tmo && !w_byte_acc) begin
            timer_d = timer_q + c_TMR_W'(1);
        end

        if (w_tmo) begin
            asm_d     = '0;
            tmo_err_d = 1'b1;
        end

        if (w_byte_acc && w_hdr_ctx) begin
            if (w_hdr_ok) begin
                asm_d  = {rab_data, 64'd0};
                cnt_d  = w_hdr_long ? 4'd8 : 4'd4;
                long_d = w_hdr_long;
            end else begin
                hdr_err_d = 1'b1;
            end
        end else if (w_byte_acc && (state_q == c_ST_PAYLOAD)) begin
            for (int i = 0; i < 8; i++) begin
                if (w_k == 4'(i)) begin
                    asm_d[63-8*i -: 8] = rab_data;
                end
            end
            cnt_d = cnt_q - 4'd1;
        end

        if (w_byte_evt && busy_q) begin
            ovr_err_d = 1'b1;
        end

        if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
        if (w_commit) begin
            hold_d      = asm_q;
            hold_bits_d = long_q ? 7'd72 : 7'd40;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge tenMHz_ext or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            sprev_q     <= 1'b0;
            asm_q       <= '0;
            cnt_q       <= '0;
            long_q      <= 1'b0;
            timer_q     <= '0;
            hold_q      <= '0;
            hold_bits_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            hdr_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            sprev_q     <= sprev_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            long_q      <= long_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            hold_bits_q <= hold_bits_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            hdr_err_q   <= hdr_err_d;
            ovr_err_q   <= ovr_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign rab_busy    = busy_q;
    assign frame_data  = hold_q;
    assign frame_bits  = hold_bits_q;
    assign frame_valid = valid_q;
    assign hdr_err     = hdr_err_q;
    assign ovr_err     = ovr_err_q;
    assign tmo_err     = tmo_err_q;

endmodule
`default_nettype wire
